s4ga_cfg_streamer: RTL and testbench
====================================

Name: s4ga_cfg_streamer

Overview:
- Transmit end of the S4GA LUT-configuration stream. Holds N packed LUT configs written by a host, sequences the fabric reset, then streams configs as SI_W-bit segments, one per clock, looping forever.
- Outputs drive the fabric's si and rst pins directly.
- Stream format: per LUT, K input-index fields of IDX_SEGS segments each, then mask of MASK_SEGS segments, all big-endian.

Parameters:
- N, 83, number of LUTs (not a multiple of LL).
- K, 5, LUT inputs.
- I, 2, FPGA inputs (sizes index field).
- SI_W, 4, segment width.
- RST_CYCLES, N+1, fabric reset length in cycles; must be > N.
- Derived in package:
  - N_W=$clog2(N)
  - IDX_W=$clog2(3+I+N)
  - IDX_SEGS=ceil(IDX_W/SI_W)
  - MASK_SEGS=ceil(2**K/SI_W)
  - LL=K*IDX_SEGS+MASK_SEGS
  - CFG_W=LL*SI_W
  - Defaults give IDX_W=7, LL=18, CFG_W=72.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- run  in  1  level; 1 = stream, 0 = stop at frame boundary
- cfg_we  in  1  host write strobe
- cfg_addr  in  N_W  LUT index to write
- cfg_wdata  in  CFG_W  packed config; bits [CFG_W-1 -: SI_W] sent first
- si_out  out  SI_W  current stream segment (fabric si)
- fab_rst  out  1  fabric reset (active high)
- lut_first  out  1  pulses with segment 0 of every LUT frame
- pass_done  out  1  pulses with last segment of LUT N-1
- busy  out  1  state != IDLE

Behaviour:
- All outputs registered. Reset values: si_out=0, fab_rst=1, lut_first=0, pass_done=0, busy=0. Reset clears state and counters, not config RAM.
- FSM:
  - IDLE: fab_rst=1, si_out=0. run=1 -> RESET with rcnt=0.
  - RESET: fab_rst=1, busy=1, rcnt increments. At rcnt==RST_CYCLES-1: load entry 0 into shift register, seg=0, lut=0 -> STREAM.
  - STREAM: fab_rst=0. Each cycle si_out = top SI_W bits of shift register, then shift left SI_W.
    - seg counts 0..LL-1; lut_first=1 when seg==0.
    - At seg==LL-1: load entry (lut==N-1 ? 0 : lut+1) and wrap lut. pass_done=1 when lut==N-1.
- Latency: first segment of LUT 0 appears the cycle after the last fab_rst=1 cycle. Frames are back-to-back with no gaps.
- run deasserted in STREAM: current frame completes through seg LL-1, then -> IDLE (fab_rst=1 next cycle). run re-asserted before the boundary: streaming continues.
- run deasserted in RESET: -> IDLE immediately.
- Writes:
  - Accepted in any state. cfg_addr>=N is ignored.
  - A write to the entry being transmitted does not alter the current frame; it takes effect on next load.
  - A write in the same cycle as a load of that address: the load takes cfg_wdata (write-first).
- rst_n low mid-stream: next cycle fab_rst=1, si_out=0, FSM IDLE. Truncated frames are permitted because the fabric is reset.
- Counters: rcnt sized $clog2(RST_CYCLES+1); seg sized $clog2(LL); no overflow beyond stated wraps.

Optional Feature:
- Macro S4GA_CFG_READBACK_EN.
- Defined: adds ports cfg_re (in, 1) and cfg_rdata (out, CFG_W). Read of cfg_addr returns data one cycle later. On a same-cycle write to that address, returns new data. cfg_rdata resets to 0.
- Undefined: ports absent; RAM is write-only from the host.

Decomposition:
- Package s4ga_pkg: derived localparams (N_W, IDX_W, IDX_SEGS, MASK_SEGS, LL, CFG_W) as functions of N/K/I/SI_W, plus FSM state enum (IDLE, RESET, STREAM).
- Sub-module s4ga_cfg_ram: N x CFG_W, one write port, one async read port for the loader; second registered read port only with readback enabled.
- Shift register, counters and FSM stay in top.

Test Plan:
- Use N=7, K=4, I=2, SI_W=4 (LL=8, CFG_W=32, RST_CYCLES=8) unless stated.
- Reset: rst_n=0 for 3 cycles -> fab_rst=1, si_out=0, busy=0, pass_done=0, lut_first=0.
- Load entry0=32'h1234ABCD, run=1 -> fab_rst=1 for exactly 8 cycles. Next 8 cycles si_out=1,2,3,4,A,B,C,D; lut_first on first only.
- Load entries i=32'hi0000000+i, run held -> pass_done on stream cycle 56 (LUT 6, seg 7). Cycle 57 is LUT 0 seg 0 with lut_first=1. Pattern repeats each 56 cycles.
- While LUT 3 seg 2 is transmitting, write entry3=32'hFFFFFFFF -> remainder of frame is old data; next pass LUT 3 sends F x8. Repeat with the write on the load cycle -> new data sent immediately.
- Drop run at LUT 2 seg 3 -> segs 4..7 still sent, then fab_rst=1, busy=0. Re-raise run -> full 8-cycle reset, restart at LUT 0.
- Pull rst_n low at LUT 4 seg 5 -> next cycle fab_rst=1, si_out=0, busy=0. Rerun streams unchanged RAM contents. With S4GA_CFG_READBACK_EN, read addr 4 returns the stored word after 1 cycle.

Source files
------------

// File: rtl/s4ga_pkg.sv
// Shared definitions for the S4GA configuration streamer: derived stream geometry and FSM states.
// The DEF_* values describe the default build and are recomputed inside each module from its own parameters.
package s4ga_pkg;

    localparam int DEF_N    = 83;
    localparam int DEF_K    = 5;
    localparam int DEF_I    = 2;
    localparam int DEF_SI_W = 4;

    function automatic int idx_w_f(input int n, input int i);
        return $clog2(3 + i + n);
    endfunction

    function automatic int idx_segs_f(input int n, input int i, input int si_w);
        return (idx_w_f(n, i) + si_w - 1) / si_w;
    endfunction

    function automatic int mask_segs_f(input int k, input int si_w);
        return ((1 << k) + si_w - 1) / si_w;
    endfunction

    function automatic int ll_f(input int n, input int k, input int i, input int si_w);
        return k * idx_segs_f(n, i, si_w) + mask_segs_f(k, si_w);
    endfunction

    function automatic int cfg_w_f(input int n, input int k, input int i, input int si_w);
        return ll_f(n, k, i, si_w) * si_w;
    endfunction

    localparam int DEF_N_W       = $clog2(DEF_N);
    localparam int DEF_IDX_W     = idx_w_f(DEF_N, DEF_I);
    localparam int DEF_IDX_SEGS  = idx_segs_f(DEF_N, DEF_I, DEF_SI_W);
    localparam int DEF_MASK_SEGS = mask_segs_f(DEF_K, DEF_SI_W);
    localparam int DEF_LL        = ll_f(DEF_N, DEF_K, DEF_I, DEF_SI_W);
    localparam int DEF_CFG_W     = cfg_w_f(DEF_N, DEF_K, DEF_I, DEF_SI_W);

    typedef enum logic [1:0] {
        IDLE,
        RESET,
        STREAM
    } state_e;

endpackage

// File: rtl/s4ga_cfg_ram.sv
// N x CFG_W LUT config store: host write port plus a write-first async read port for the stream loader.
// Defining S4GA_CFG_READBACK_EN adds a registered host read port.
module s4ga_cfg_ram
    import s4ga_pkg::*;
#(
    parameter int  N     = DEF_N,
    parameter int  CFG_W = DEF_CFG_W,
    localparam int N_W   = $clog2(N)
) (
    input  logic             clk,
`ifdef S4GA_CFG_READBACK_EN
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic [N_W-1:0]   rd_addr,
    output logic [CFG_W-1:0] rd_data,
`endif
    input  logic             we,
    input  logic [N_W-1:0]   waddr,
    input  logic [CFG_W-1:0] wdata,
    input  logic [N_W-1:0]   load_addr,
    output logic [CFG_W-1:0] load_data
);

    logic [CFG_W-1:0] mem [N];
    logic             wr_ok;

    assign wr_ok = we && (int'(waddr) < N);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // The loader address is always in range, so a matching write can be forwarded directly.
    assign load_data = (wr_ok && (waddr == load_addr)) ? wdata : mem[load_addr];

`ifdef S4GA_CFG_READBACK_EN
    logic [CFG_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            if (wr_ok && (waddr == rd_addr)) begin
                rd_data_d = wdata;
            end else if (int'(rd_addr) < N) begin
                rd_data_d = mem[rd_addr];
            end else begin
                rd_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`else
`endif

endmodule

// File: rtl/s4ga_cfg_streamer.sv
// Streams stored LUT configs to the S4GA fabric after a timed fabric reset, looping over all LUTs.
// Optional host readback of the config RAM is enabled with S4GA_CFG_READBACK_EN.
module s4ga_cfg_streamer
    import s4ga_pkg::*;
#(
    parameter int  N          = DEF_N,
    parameter int  K          = DEF_K,
    parameter int  I          = DEF_I,
    parameter int  SI_W       = DEF_SI_W,
    parameter int  RST_CYCLES = N + 1,
    localparam int N_W        = $clog2(N),
    localparam int LL         = ll_f(N, K, I, SI_W),
    localparam int CFG_W      = LL * SI_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             cfg_we,
    input  logic [N_W-1:0]   cfg_addr,
    input  logic [CFG_W-1:0] cfg_wdata,
    output logic [SI_W-1:0]  si_out,
    output logic             fab_rst,
    output logic             lut_first,
    output logic             pass_done,
    output logic             busy
`ifdef S4GA_CFG_READBACK_EN
    ,
    input  logic             cfg_re,
    output logic [CFG_W-1:0] cfg_rdata
`endif
);

    localparam int SEG_W  = $clog2(LL);
    localparam int RCNT_W = $clog2(RST_CYCLES + 1);

    localparam logic [N_W-1:0]    LAST_LUT = N_W'(N - 1);
    localparam logic [SEG_W-1:0]  LAST_SEG = SEG_W'(LL - 1);
    localparam logic [RCNT_W-1:0] LAST_RST = RCNT_W'(RST_CYCLES - 1);

    state_e            state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic [N_W-1:0]    lut_q, lut_d;
    logic [CFG_W-1:0]  shift_q, shift_d;
    logic [SI_W-1:0]   si_out_q, si_out_d;
    logic              fab_rst_q, fab_rst_d;
    logic              lut_first_q, lut_first_d;
    logic              pass_done_q, pass_done_d;
    logic              busy_q, busy_d;
    logic [N_W-1:0]    load_addr;
    logic [CFG_W-1:0]  load_data;

    // Entry 0 is loaded when leaving RESET; otherwise the successor of the LUT in flight.
    assign load_addr = (state_q == STREAM && lut_q != LAST_LUT) ? lut_q + 1'b1 : '0;

    s4ga_cfg_ram #(
        .N     (N),
        .CFG_W (CFG_W)
    ) u_ram (
        .clk       (clk),
`ifdef S4GA_CFG_READBACK_EN
        .rst_n     (rst_n),
        .rd_en     (cfg_re),
        .rd_addr   (cfg_addr),
        .rd_data   (cfg_rdata),
`endif
        .we        (cfg_we),
        .waddr     (cfg_addr),
        .wdata     (cfg_wdata),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        seg_d   = seg_q;
        lut_d   = lut_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = RESET;
                    rcnt_d  = '0;
                end
            end
            RESET: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (rcnt_q == LAST_RST) begin
                    shift_d = load_data;
                    seg_d   = '0;
                    lut_d   = '0;
                    state_d = STREAM;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            STREAM: begin
                if (seg_q == LAST_SEG) begin
                    shift_d = load_data;
                    seg_d   = '0;
                    lut_d   = load_addr;
                    if (!run) begin
                        state_d = IDLE;
                    end
                end else begin
                    shift_d = shift_q << SI_W;
                    seg_d   = seg_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        fab_rst_d   = (state_d != STREAM);
        busy_d      = (state_d != IDLE);
        si_out_d    = (state_d == STREAM) ? shift_d[CFG_W-1 -: SI_W] : '0;
        lut_first_d = (state_d == STREAM) && (seg_d == '0);
        pass_done_d = (state_d == STREAM) && (seg_d == LAST_SEG) && (lut_d == LAST_LUT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rcnt_q      <= '0;
            seg_q       <= '0;
            lut_q       <= '0;
            shift_q     <= '0;
            si_out_q    <= '0;
            fab_rst_q   <= 1'b1;
            lut_first_q <= 1'b0;
            pass_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            seg_q       <= seg_d;
            lut_q       <= lut_d;
            shift_q     <= shift_d;
            si_out_q    <= si_out_d;
            fab_rst_q   <= fab_rst_d;
            lut_first_q <= lut_first_d;
            pass_done_q <= pass_done_d;
            busy_q      <= busy_d;
        end
    end

    assign si_out    = si_out_q;
    assign fab_rst   = fab_rst_q;
    assign lut_first = lut_first_q;
    assign pass_done = pass_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_s4ga_cfg_streamer.sv
// Directed self-checking bench for s4ga_cfg_streamer with N=7, K=4, I=2, SI_W=4 (LL=8, CFG_W=32).
// Build with S4GA_CFG_READBACK_EN defined to also exercise the readback port.
module tb_s4ga_cfg_streamer;

    localparam int N  = 7;
    localparam int LL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [3:0]  si_out;
    logic        fab_rst;
    logic        lut_first;
    logic        pass_done;
    logic        busy;
`ifdef S4GA_CFG_READBACK_EN
    logic        cfg_re;
    logic [31:0] cfg_rdata;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [N];
    logic [31:0] cur_word;
    int          exp_lut;
    int          exp_seg;
    logic        run_lvl;
    bit          wr_pend;
    int          wr_lut;
    int          wr_seg;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;

    always #5 clk = ~clk;

    s4ga_cfg_streamer #(
        .N          (7),
        .K          (4),
        .I          (2),
        .SI_W       (4),
        .RST_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .si_out    (si_out),
        .fab_rst   (fab_rst),
        .lut_first (lut_first),
        .pass_done (pass_done),
`ifdef S4GA_CFG_READBACK_EN
        .cfg_re    (cfg_re),
        .cfg_rdata (cfg_rdata),
`endif
        .busy      (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h lut=%0d seg=%0d t=%0t", tag, got, exp, exp_lut, exp_seg, $time);
        end
    endtask

    // Drive one cycle of inputs; on return the outputs reflect the edge that sampled them.
    task automatic applyStimulus(input logic rv, input logic runv, input logic wev,
                                 input logic [2:0] av, input logic [31:0] dv);
        rst_n     = rv;
        run       = runv;
        cfg_we    = wev;
        cfg_addr  = av;
        cfg_wdata = dv;
        @(negedge clk);
    endtask

    task automatic measureReset();
        int cnt   = 0;
        int guard = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'h0);
        while (fab_rst === 1'b1 && guard < 20) begin
            if (busy === 1'b1) cnt++;
            applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'h0);
            guard++;
        end
        checkOutput("rst_len", 32'(cnt), 32'd8);
        exp_lut  = 0;
        exp_seg  = 0;
        cur_word = model_mem[0];
    endtask

    task automatic runStream(input int cycles);
        logic        we;
        logic [3:0]  nib;
        for (int c = 0; c < cycles; c++) begin
            nib = cur_word[31 - 4*exp_seg -: 4];
            checkOutput("si_out", 32'(si_out), 32'(nib));
            checkOutput("lut_first", 32'(lut_first), 32'(exp_seg == 0));
            checkOutput("pass_done", 32'(pass_done), 32'(exp_lut == N-1 && exp_seg == LL-1));
            checkOutput("fab_rst", 32'(fab_rst), 32'd0);
            checkOutput("busy", 32'(busy), 32'd1);
            we = 1'b0;
            if (wr_pend && exp_lut == wr_lut && exp_seg == wr_seg) begin
                we = 1'b1;
                model_mem[wr_addr] = wr_data;
                wr_pend = 1'b0;
            end
            applyStimulus(1'b1, run_lvl, we, wr_addr, wr_data);
            if (exp_seg == LL-1) begin
                exp_seg  = 0;
                exp_lut  = (exp_lut + 1) % N;
                cur_word = model_mem[exp_lut];
            end else begin
                exp_seg++;
            end
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_fab_rst"}, 32'(fab_rst), 32'd1);
        checkOutput({tag, "_si_out"}, 32'(si_out), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_lut_first"}, 32'(lut_first), 32'd0);
        checkOutput({tag, "_pass_done"}, 32'(pass_done), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        wr_pend = 1'b0;
        wr_addr = 3'd0;
        wr_data = 32'h0;
        run_lvl = 1'b0;
        exp_lut = 0;
        exp_seg = 0;
`ifdef S4GA_CFG_READBACK_EN
        cfg_re = 1'b0;
`endif
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
        checkIdle("reset");

        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h1234ABCD);
        model_mem[0] = 32'h1234ABCD;
        for (int i = 1; i < N; i++) begin
            d = (32'(i) << 28) | 32'(i);
            applyStimulus(1'b1, 1'b0, 1'b1, 3'(i), d);
            model_mem[i] = d;
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd7, 32'hDEADBEEF);
        checkIdle("idle");

        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'd1);
        checkOutput("rst_fab_rst", 32'(fab_rst), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
        checkIdle("abort");
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);

        run_lvl = 1'b1;
        measureReset();
        runStream(56);
        runStream(8);

        wr_pend = 1'b1; wr_lut = 3; wr_seg = 2; wr_addr = 3'd3; wr_data = 32'hFFFFFFFF;
        runStream(48);
        runStream(56);

        wr_pend = 1'b1; wr_lut = 1; wr_seg = 7; wr_addr = 3'd2; wr_data = 32'h5A5A5A5A;
        runStream(19);
        run_lvl = 1'b0;
        runStream(5);
        checkIdle("stop");
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
        checkOutput("stop_hold_busy", 32'(busy), 32'd0);

        run_lvl = 1'b1;
        measureReset();
        runStream(37);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 32'h0);
        checkIdle("midrst");
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
        measureReset();
        runStream(56);

`ifdef S4GA_CFG_READBACK_EN
        cfg_re = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd4, 32'h0);
        cfg_re = 1'b0;
        checkOutput("readback", cfg_rdata, model_mem[4]);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
